// File: rtl/sb_rx_deserializer_if.sv
// Sideband RX deserializer bus: serial lane and enable in, assembled words and status out.
interface sb_rx_deserializer_if;
    logic        i_enable;
    logic        RXDATASB;
    logic [63:0] o_data;
    logic        o_valid;
    logic        o_aligned;
    logic        o_pattern_det;

    modport master (
        output i_enable,
        output RXDATASB,
        input  o_data,
        input  o_valid,
        input  o_aligned,
        input  o_pattern_det
    );

    modport slave (
        input  i_enable,
        input  RXDATASB,
        output o_data,
        output o_valid,
        output o_aligned,
        output o_pattern_det
    );
endinterface

// File: rtl/sb_rx_deserializer.sv
// Sideband RX deserializer: hunts for the first 1 of a session, then assembles 64-bit words MSB-first.
// Define SB_RX_PATTERN_DET_EN to compile in the SBINIT clock-pattern detector.
module sb_rx_deserializer (
    input  logic                 i_pll_clk,
    input  logic                 i_rst_n,
    sb_rx_deserializer_if.slave  sb
);

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        CAPTURE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  bit_cnt;
    logic [63:0] shift_q;
    logic [63:0] data_q;
    logic        valid_q;
    logic [63:0] word_nxt;
    logic        word_done;

    assign word_nxt  = {shift_q[62:0], sb.RXDATASB};
    // Disable on the completing edge wins, so the strobe is gated by enable.
    assign word_done = sb.i_enable && (state == CAPTURE) && (bit_cnt == 6'd63);

    always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!sb.i_enable) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nxt = HUNT;
                HUNT:    if (sb.RXDATASB) state_nxt = CAPTURE;
                CAPTURE: state_nxt = CAPTURE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!sb.i_enable) begin
                bit_cnt <= '0;
                shift_q <= '0;
            end else if (state == HUNT && sb.RXDATASB) begin
                shift_q <= 64'd1;
                bit_cnt <= 6'd1;
            end else if (state == CAPTURE) begin
                shift_q <= word_nxt;
                bit_cnt <= bit_cnt + 6'd1;
                if (word_done) begin
                    data_q  <= word_nxt;
                    valid_q <= 1'b1;
                end
            end
        end
    end

`ifdef SB_RX_PATTERN_DET_EN
    localparam logic [63:0] PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;

    logic [1:0] match_cnt;
    logic       pat_det_q;

    // Flag rises on the edge the saturating match count reaches 2, then stays until IDLE.
    always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            match_cnt <= '0;
            pat_det_q <= 1'b0;
        end else if (!sb.i_enable) begin
            match_cnt <= '0;
            pat_det_q <= 1'b0;
        end else if (word_done) begin
            if (word_nxt == PATTERN) begin
                if (match_cnt != 2'd2) match_cnt <= match_cnt + 2'd1;
                if (match_cnt != 2'd0) pat_det_q <= 1'b1;
            end else begin
                match_cnt <= '0;
            end
        end
    end
`endif

    always_comb begin
        sb.o_data    = data_q;
        sb.o_valid   = valid_q;
        sb.o_aligned = (state == CAPTURE);
`ifdef SB_RX_PATTERN_DET_EN
        sb.o_pattern_det = pat_det_q;
`else
        sb.o_pattern_det = 1'b0;
`endif
    end

endmodule

// File: tb/tb_sb_rx_deserializer.sv
// Directed bench for sb_rx_deserializer with a word scoreboard checked on every o_valid strobe.
module tb_sb_rx_deserializer;

    localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;

    logic i_pll_clk = 1'b0;
    logic i_rst_n   = 1'b0;

    sb_rx_deserializer_if sb ();

    sb_rx_deserializer dut (
        .i_pll_clk (i_pll_clk),
        .i_rst_n   (i_rst_n),
        .sb        (sb)
    );

    always #5 i_pll_clk = ~i_pll_clk;

    typedef struct {
        logic [63:0] data;
        logic        det;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk     = 0;
    int          n_fail    = 0;
    int unsigned cyc       = 0;
    int unsigned n_strobes = 0;
    int unsigned m_cnt     = 0;
    logic        m_det     = 1'b0;
    logic [63:0] last_word = '0;

    always @(posedge i_pll_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model for one completed word; strobe expected one posedge after the last bit is driven.
    task automatic push_word(input logic [63:0] w);
        exp_t e;
        if (w == PAT) begin
            if (m_cnt >= 1) m_det = 1'b1;
            if (m_cnt < 2) m_cnt++;
        end else begin
            m_cnt = 0;
        end
        e.data = w;
`ifdef SB_RX_PATTERN_DET_EN
        e.det = m_det;
`else
        e.det = 1'b0;
`endif
        e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_det = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge i_pll_clk);
        sb.RXDATASB = b;
    endtask

    task automatic send_word(input logic [63:0] w, input bit chk_align);
        for (int i = 63; i >= 0; i--) begin
            @(negedge i_pll_clk);
            if (chk_align && i == 63) check("aligned_while_hunting", {63'b0, sb.o_aligned}, 64'd0);
            if (chk_align && i == 62) check("aligned_after_first_one", {63'b0, sb.o_aligned}, 64'd1);
            sb.RXDATASB = w[i];
        end
        push_word(w);
        last_word = w;
    endtask

    always @(negedge i_pll_clk) begin
        if (sb.o_valid === 1'b1) begin
            n_strobes++;
            n_chk++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_strobe: observed data %h with no pending word", sb.o_data);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_data", sb.o_data, e.data);
                check("strobe_cycle", 64'(cyc), 64'(e.cyc));
                check("strobe_pattern_det", {63'b0, sb.o_pattern_det}, {63'b0, e.det});
            end
        end
    end

    initial begin
        logic [63:0] w2;
        logic [63:0] w3;
        int unsigned strobes_before;

        w2 = 64'hC3C3_5A5A_0F0F_9696;
        w3 = 64'h9ABC_DEF0_1357_2468;
        sb.i_enable = 1'b0;
        sb.RXDATASB = 1'b0;

        #1;
        check("reset_data", sb.o_data, 64'd0);
        check("reset_valid", {63'b0, sb.o_valid}, 64'd0);
        check("reset_aligned", {63'b0, sb.o_aligned}, 64'd0);
        check("reset_pattern_det", {63'b0, sb.o_pattern_det}, 64'd0);
        repeat (2) @(negedge i_pll_clk);
        i_rst_n = 1'b1;

        // Hunt and align after leading zeros.
        sb.i_enable = 1'b1;
        repeat (10) send_bit(1'b0);
        send_word(64'h8000_0000_0000_0001, 1'b1);

        // Back-to-back words across the counter wrap.
        send_word(PAT, 1'b0);
        send_word(64'hF0F0_1234_5678_9ABC, 1'b0);
        send_word(64'hDEAD_BEEF_0000_FFFF, 1'b0);

        // Pattern detect: two consecutive patterns needed, then sticky.
        send_word(PAT, 1'b0);
        send_word(64'h0, 1'b0);
        send_word(PAT, 1'b0);
        send_word(PAT, 1'b0);
        send_word(64'h1234_5678_9ABC_DEF0, 1'b0);

        // Disable at bit 40 of a word.
        for (int i = 63; i > 40; i--) send_bit(w2[i]);
        @(negedge i_pll_clk);
        sb.i_enable = 1'b0;
        sb.RXDATASB = w2[40];
        @(negedge i_pll_clk);
        check("disable_valid", {63'b0, sb.o_valid}, 64'd0);
        check("disable_data_held", sb.o_data, last_word);
        check("disable_aligned", {63'b0, sb.o_aligned}, 64'd0);
        check("disable_pattern_det", {63'b0, sb.o_pattern_det}, 64'd0);
        model_clear();
        sb.RXDATASB = 1'b0;
        repeat (4) send_bit(1'b0);

        // Re-enable re-hunts.
        sb.i_enable = 1'b1;
        repeat (5) send_bit(1'b0);
        send_word(64'hDEAD_BEEF_0000_FFFF, 1'b1);

        // Disable on the edge sampling bit 0.
        for (int i = 63; i > 0; i--) send_bit(w3[i]);
        @(negedge i_pll_clk);
        sb.i_enable = 1'b0;
        sb.RXDATASB = w3[0];
        @(negedge i_pll_clk);
        check("simul_valid", {63'b0, sb.o_valid}, 64'd0);
        check("simul_data_held", sb.o_data, last_word);
        check("simul_aligned", {63'b0, sb.o_aligned}, 64'd0);
        model_clear();
        sb.RXDATASB = 1'b0;
        repeat (3) send_bit(1'b0);

        // Asynchronous reset in the middle of a word.
        sb.i_enable = 1'b1;
        repeat (3) send_bit(1'b0);
        for (int i = 63; i >= 20; i--) send_bit(w3[i]);
        @(negedge i_pll_clk);
        check("pre_reset_aligned", {63'b0, sb.o_aligned}, 64'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check("midword_reset_data", sb.o_data, 64'd0);
        check("midword_reset_valid", {63'b0, sb.o_valid}, 64'd0);
        check("midword_reset_aligned", {63'b0, sb.o_aligned}, 64'd0);
        check("midword_reset_pattern_det", {63'b0, sb.o_pattern_det}, 64'd0);
        model_clear();
        sb.RXDATASB = 1'b0;
        @(negedge i_pll_clk);
        i_rst_n = 1'b1;
        strobes_before = n_strobes;
        repeat (200) send_bit(1'b0);
        check("post_reset_no_strobes", 64'(n_strobes - strobes_before), 64'd0);
        check("post_reset_aligned", {63'b0, sb.o_aligned}, 64'd0);

        repeat (3) send_bit(1'b0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
